// File: rtl/fm_freeze_ctrl.sv
// Freeze controller for the spy-buffer bank: arm/trigger/post-trigger sequencing,
// software freeze, and a timed spy-memory initialisation strobe.
module fm_freeze_ctrl #(
  parameter int SB_N  = 29,
  parameter int CNT_W = 16
) (
  input  logic             spy_clock,
  input  logic             axi_reset_n,
  input  logic             arm,
  input  logic             trig_in,
  input  logic             sw_freeze,
  input  logic             release_req,
  input  logic             init_req,
  input  logic [SB_N-1:0]  freeze_mask,
  input  logic [CNT_W-1:0] post_trig_cnt,
  input  logic [CNT_W-1:0] init_len,
  output logic [SB_N-1:0]  freeze,
  output logic             init_spy_mem,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] trig_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_ARMED  = 3'd2,
    ST_POST   = 3'd3,
    ST_FROZEN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [SB_N-1:0]  mask_q_r;
  logic [SB_N-1:0]  mask_next_s;
  logic             trig_prev_r;
  logic             trig_edge_s;
  logic             accept_s;
  logic             tc_inc_s;
  logic             tc_clr_s;
  logic [CNT_W-1:0] tc_next_s;
  logic [SB_N-1:0]  freeze_next_s;

  assign trig_edge_s = trig_in & ~trig_prev_r;
  assign accept_s    = trig_edge_s | sw_freeze;
  assign state       = state_r;

  // Next-state, counter, mask and trigger-count decisions
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    mask_next_s  = mask_q_r;
    tc_inc_s     = 1'b0;
    tc_clr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (init_req) begin
          next_state_s = ST_INIT;
          cnt_next_s   = (init_len == CNT_ZERO) ? CNT_ONE : init_len;
        end else if (arm) begin
          next_state_s = ST_ARMED;
          tc_clr_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (cnt_r <= CNT_ONE) begin
          next_state_s = ST_IDLE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r - CNT_ONE;
        end
      end
      ST_ARMED: begin
        // A trigger in the same cycle as release_req takes precedence
        if (accept_s) begin
          mask_next_s = freeze_mask;
          tc_inc_s    = 1'b1;
          if (post_trig_cnt == CNT_ZERO) begin
            next_state_s = ST_FROZEN;
            cnt_next_s   = CNT_ZERO;
          end else begin
            next_state_s = ST_POST;
            cnt_next_s   = post_trig_cnt;
          end
        end else if (release_req) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ARMED;
        end
      end
      ST_POST: begin
        tc_inc_s = trig_edge_s;
        if (release_req) begin
          next_state_s = ST_IDLE;
          cnt_next_s   = CNT_ZERO;
        end else if (sw_freeze || (cnt_r <= CNT_ONE)) begin
          next_state_s = ST_FROZEN;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r - CNT_ONE;
        end
      end
      ST_FROZEN: begin
        tc_inc_s = trig_edge_s;
        if (release_req) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FROZEN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Saturating trigger count and output values for the state being entered
  always_comb begin
    tc_next_s     = trig_count;
    freeze_next_s = {SB_N{1'b0}};
    if (tc_clr_s) begin
      tc_next_s = CNT_ZERO;
    end else if (tc_inc_s && (trig_count != CNT_MAX)) begin
      tc_next_s = trig_count + CNT_ONE;
    end else begin
      tc_next_s = trig_count;
    end
    if (next_state_s == ST_FROZEN) begin
      freeze_next_s = mask_next_s;
    end else begin
      freeze_next_s = {SB_N{1'b0}};
    end
  end

  // State, counters and registered outputs; trig_prev resets high so a held trigger is not an edge
  always_ff @(posedge spy_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      mask_q_r     <= {SB_N{1'b0}};
      trig_prev_r  <= 1'b1;
      freeze       <= {SB_N{1'b0}};
      init_spy_mem <= 1'b0;
      trig_count   <= CNT_ZERO;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= cnt_next_s;
      mask_q_r     <= mask_next_s;
      trig_prev_r  <= trig_in;
      freeze       <= freeze_next_s;
      init_spy_mem <= (next_state_s == ST_INIT);
      trig_count   <= tc_next_s;
    end
  end

endmodule

// File: tb/tb_fm_freeze_ctrl.sv
// Directed self-checking bench for fm_freeze_ctrl (CNT_W=4 so saturation is reachable).
module tb_fm_freeze_ctrl;

  localparam int SB_N  = 29;
  localparam int CNT_W = 4;

  logic             spy_clock = 1'b0;
  logic             axi_reset_n;
  logic             arm, trig_in, sw_freeze, release_req, init_req;
  logic [SB_N-1:0]  freeze_mask;
  logic [CNT_W-1:0] post_trig_cnt, init_len;
  logic [SB_N-1:0]  freeze;
  logic             init_spy_mem;
  logic [2:0]       state;
  logic [CNT_W-1:0] trig_count;

  int tests = 0;
  int fails = 0;

  fm_freeze_ctrl #(.SB_N(SB_N), .CNT_W(CNT_W)) dut (
    .spy_clock    (spy_clock),
    .axi_reset_n  (axi_reset_n),
    .arm          (arm),
    .trig_in      (trig_in),
    .sw_freeze    (sw_freeze),
    .release_req  (release_req),
    .init_req     (init_req),
    .freeze_mask  (freeze_mask),
    .post_trig_cnt(post_trig_cnt),
    .init_len     (init_len),
    .freeze       (freeze),
    .init_spy_mem (init_spy_mem),
    .state        (state),
    .trig_count   (trig_count)
  );

  always #5 spy_clock = ~spy_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge spy_clock);
    #1;
  endtask

  initial begin
    axi_reset_n = 1'b0; arm = 1'b0; trig_in = 1'b0; sw_freeze = 1'b0;
    release_req = 1'b0; init_req = 1'b0; freeze_mask = 29'h0;
    post_trig_cnt = 4'd0; init_len = 4'd0;
    #12;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_freeze", {3'd0, freeze}, 32'd0);
    chk("rst_init", {31'd0, init_spy_mem}, 32'd0);
    chk("rst_tc", {28'd0, trig_count}, 32'd0);
    step();
    axi_reset_n = 1'b1;
    step();

    // init with length 4
    init_len = 4'd4; init_req = 1'b1;
    step(); init_req = 1'b0;
    chk("init4_state", {29'd0, state}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("init4_high", {31'd0, init_spy_mem}, 32'd1);
      step();
    end
    chk("init4_high_last", {31'd0, init_spy_mem}, 32'd1);
    step();
    chk("init4_low", {31'd0, init_spy_mem}, 32'd0);
    chk("init4_idle", {29'd0, state}, 32'd0);

    // init with length 0 behaves as 1
    init_len = 4'd0; init_req = 1'b1;
    step(); init_req = 1'b0;
    chk("init0_high", {31'd0, init_spy_mem}, 32'd1);
    step();
    chk("init0_low", {31'd0, init_spy_mem}, 32'd0);
    chk("init0_idle", {29'd0, state}, 32'd0);

    // delayed trigger, post_trig_cnt=10
    freeze_mask = 29'h3; post_trig_cnt = 4'd10; arm = 1'b1;
    step(); arm = 1'b0;
    chk("arm_state", {29'd0, state}, 32'd2);
    chk("arm_tc", {28'd0, trig_count}, 32'd0);
    trig_in = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      chk("post_state", {29'd0, state}, 32'd3);
      chk("post_freeze", {3'd0, freeze}, 32'd0);
      step();
    end
    chk("post_last", {29'd0, state}, 32'd3);
    step();
    chk("dly_frozen", {29'd0, state}, 32'd4);
    chk("dly_freeze", {3'd0, freeze}, 32'h3);
    chk("dly_tc", {28'd0, trig_count}, 32'd1);
    freeze_mask = 29'h1F;
    step();
    chk("mask_hold", {3'd0, freeze}, 32'h3);
    release_req = 1'b1;
    step(); release_req = 1'b0;
    chk("rel_state", {29'd0, state}, 32'd0);
    chk("rel_freeze", {3'd0, freeze}, 32'd0);

    // zero delay
    trig_in = 1'b0; post_trig_cnt = 4'd0; freeze_mask = 29'h5; arm = 1'b1;
    step(); arm = 1'b0;
    trig_in = 1'b1;
    step();
    chk("zd_state", {29'd0, state}, 32'd4);
    chk("zd_freeze", {3'd0, freeze}, 32'h5);
    release_req = 1'b1;
    step(); release_req = 1'b0;
    chk("zd_rel_state", {29'd0, state}, 32'd0);
    chk("zd_rel_freeze", {3'd0, freeze}, 32'd0);

    // trigger and release together, then sw_freeze in POST at counter 7
    trig_in = 1'b0; post_trig_cnt = 4'd10; freeze_mask = 29'h1234567; arm = 1'b1;
    step(); arm = 1'b0;
    trig_in = 1'b1; release_req = 1'b1;
    step(); release_req = 1'b0;
    chk("sim_trig_wins", {29'd0, state}, 32'd3);
    chk("sim_tc", {28'd0, trig_count}, 32'd1);
    step(); step(); step();
    chk("sw_pre", {29'd0, state}, 32'd3);
    sw_freeze = 1'b1;
    step(); sw_freeze = 1'b0;
    chk("sw_state", {29'd0, state}, 32'd4);
    chk("sw_freeze", {3'd0, freeze}, 32'h1234567);

    // saturation: 20 trigger edges while FROZEN
    for (int i = 0; i < 20; i++) begin
      trig_in = 1'b0; step();
      trig_in = 1'b1; step();
    end
    chk("sat_tc", {28'd0, trig_count}, 32'd15);
    chk("sat_state", {29'd0, state}, 32'd4);
    arm = 1'b1; init_req = 1'b1;
    step(); arm = 1'b0; init_req = 1'b0;
    chk("frz_ignore_arm", {29'd0, state}, 32'd4);
    chk("frz_ignore_tc", {28'd0, trig_count}, 32'd15);

    // asynchronous reset mid-cycle while FROZEN, trig_in held high
    #2 axi_reset_n = 1'b0;
    #1;
    chk("arst_freeze", {3'd0, freeze}, 32'd0);
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_tc", {28'd0, trig_count}, 32'd0);
    step();
    axi_reset_n = 1'b1;
    step();
    arm = 1'b1;
    step(); arm = 1'b0;
    step(); step();
    chk("held_no_trig", {29'd0, state}, 32'd2);
    chk("held_tc", {28'd0, trig_count}, 32'd0);
    trig_in = 1'b0; step();
    trig_in = 1'b1; step();
    chk("retrig_state", {29'd0, state}, 32'd3);
    chk("retrig_tc", {28'd0, trig_count}, 32'd1);
    release_req = 1'b1;
    step(); release_req = 1'b0;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_freeze", {3'd0, freeze}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
